sevseg_frame_decoder: RTL and testbench
=======================================

SEVSEG_FRAME_DECODER -- requirements
Module: sevseg_frame_decoder

Interface
REQ-001 SHALL have parameter ERR_CNT_W, default 8, width of the saturating error counter.
REQ-002 SHALL have parameter FRM_CNT_W, default 16, width of the wrapping frame counter.
REQ-003 SHALL have port clk_7seg  input  1  scan clock; all state updates on its rising edge.
REQ-004 SHALL have port Rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port an  input  8  active-low one-hot digit select; bit k low = digit k.
REQ-006 SHALL have port sev_out  input  7  active-low segment pattern for the selected digit.
REQ-007 SHALL have port cap_en  input  1  capture enable.
REQ-008 SHALL have port frame_ack  input  1  consumer acknowledge of frame_data.
REQ-009 SHALL have port frame_data  output  32  last published word; digit k maps to bits [4k+3:4k].
REQ-010 SHALL have port frame_valid  output  1  frame_data holds an unacknowledged frame.
REQ-011 SHALL have port overrun  output  1  sticky flag: a frame completed while frame_valid was high and not acked.
REQ-012 SHALL have port seg_err  output  1  one-cycle pulse: invalid segment pattern or digit-sequence error.
REQ-013 SHALL have port err_cnt  output  ERR_CNT_W  saturating error count.
REQ-014 SHALL have port frame_cnt  output  FRM_CNT_W  published-frame count; wraps to 0.

Function
REQ-015 SHALL have a state machine with states HUNT and COLLECT and a digit index idx[2:0].
REQ-016 In HUNT, when cap_en=1, an=8'b11111110 and sev_out is valid, SHALL store nibble 0, set idx=1 and go to COLLECT.
REQ-017 In COLLECT, when an equals the one-hot-low pattern for idx and sev_out is valid, SHALL store nibble idx and increment idx.
REQ-018 When digit 7 is stored, SHALL update frame_data with the assembled word on the same edge: visible one cycle after a7 is sampled, no further latency. SHALL also set frame_valid=1, increment frame_cnt, and return to HUNT.
REQ-019 In COLLECT, an that is not the expected pattern, including non-one-hot or all-ones, SHALL pulse seg_err, discard the partial word and go to HUNT.
REQ-020 A sev_out value not in the 16-entry code table SHALL pulse seg_err, discard the partial word and go to HUNT, in either state.
REQ-021 SHALL decode patterns in hex order 0-F as: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100, 0001000, 1100000, 0110001, 1000010, 0110000, 0111000.
REQ-022 cap_en=0 SHALL force HUNT and discard any partial word. SHALL NOT affect frame_data, frame_valid or the counters. Invalid input while cap_en=0 SHALL NOT raise seg_err.
REQ-023 frame_ack=1 while frame_valid=1 SHALL clear frame_valid next cycle. frame_ack while frame_valid=0 SHALL be ignored.
REQ-024 A frame completion with frame_valid=1 and frame_ack=0 SHALL set overrun and SHALL keep the old frame_data. frame_cnt SHALL NOT increment.
REQ-025 Simultaneous completion and frame_ack SHALL publish the new word, keep frame_valid=1 and leave overrun unchanged.
REQ-026 err_cnt SHALL increment on each seg_err and hold at all-ones.
REQ-027 overrun SHALL clear only on Rst.

Reset
REQ-028 On Rst: state=HUNT, idx=0, frame_data=0, frame_valid=0, overrun=0, seg_err=0, err_cnt=0, frame_cnt=0.
REQ-029 Rst SHALL take priority over all other inputs, including a frame completing mid-operation.

Configuration
REQ-030 With SEVSEG_DEC_STABLE_EN defined, a completed word SHALL publish only if it equals the previous completed word, held in a compare register cleared on Rst and on any error. A non-matching word updates the compare register only. frame_cnt counts only published words.
REQ-031 Without SEVSEG_DEC_STABLE_EN, every completed word SHALL publish per REQ-018. The compare register SHALL be absent.

Structure
REQ-032 Package sevseg_pkg SHALL hold the 16-entry code table constant, the an one-hot-low constants a0..a7 and the state enum typedef.
REQ-033 One sub-module, sevseg_digit_decode, SHALL be combinational: input 7-bit pattern, outputs nibble[3:0] and valid.

Verification
REQ-034 Scan value 32'h89ABCDEF with cap_en=1 (an a0..a7, matching sev_out) -> frame_data=32'h89ABCDEF and frame_valid=1 one cycle after a7, frame_cnt=1.
REQ-035 Two frames 32'h00000001 then 32'h00000002 with no frame_ack -> frame_data stays 32'h00000001, overrun=1, frame_cnt=1.
REQ-036 Scan a0,a1 then a3 -> seg_err pulse, err_cnt=1, no publish. The next full scan of 32'h12345678 publishes correctly.
REQ-037 sev_out=7'b1111111 at digit 2 -> seg_err pulse, HUNT. With 300 consecutive errors and ERR_CNT_W=8 -> err_cnt=255.
REQ-038 frame_ack asserted on the same cycle as a completion -> frame_valid stays 1 with the new data. Rst asserted at digit 5 -> all outputs 0 next cycle.
REQ-039 With SEVSEG_DEC_STABLE_EN, scan 32'hA5A5A5A5 once -> frame_valid=0. Scan it a second time -> frame_valid=1.

Source files
------------

// File: rtl/sevseg_pkg.sv
// Shared definitions for the seven-segment frame decoder: the active-low segment
// code table, the active-low one-hot digit-select patterns and the FSM state type.
package sevseg_pkg;

  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  // Index i holds the active-low pattern {a,b,c,d,e,f,g} that displays hex digit i
  localparam logic [0:15][6:0] SEG_CODE = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  localparam logic [7:0] AN_A0 = 8'b1111_1110;
  localparam logic [7:0] AN_A1 = 8'b1111_1101;
  localparam logic [7:0] AN_A2 = 8'b1111_1011;
  localparam logic [7:0] AN_A3 = 8'b1111_0111;
  localparam logic [7:0] AN_A4 = 8'b1110_1111;
  localparam logic [7:0] AN_A5 = 8'b1101_1111;
  localparam logic [7:0] AN_A6 = 8'b1011_1111;
  localparam logic [7:0] AN_A7 = 8'b0111_1111;

  localparam logic [0:7][7:0] AN_SEL = '{
    AN_A0, AN_A1, AN_A2, AN_A3, AN_A4, AN_A5, AN_A6, AN_A7
  };

endpackage

// File: rtl/sevseg_digit_decode.sv
// Combinational lookup of a 7-bit active-low segment pattern into its hex nibble;
// valid is low when the pattern is not one of the sixteen table entries.
module sevseg_digit_decode
  import sevseg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       valid
);

  always_comb begin
    nibble = 4'd0;
    valid  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (pattern == SEG_CODE[i]) begin
        nibble = 4'(i);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sevseg_frame_decoder.sv
// Rebuilds a 32-bit word from a multiplexed 8-digit seven-segment scan; frames publish one cycle
// after digit 7. SEVSEG_DEC_STABLE_EN publishes a word only when two consecutive scans agree.
module sevseg_frame_decoder
  import sevseg_pkg::*;
#(
  parameter int ERR_CNT_W = 8,
  parameter int FRM_CNT_W = 16
) (
  input  logic                 clk_7seg,
  input  logic                 Rst,
  input  logic [7:0]           an,
  input  logic [6:0]           sev_out,
  input  logic                 cap_en,
  input  logic                 frame_ack,
  output logic [31:0]          frame_data,
  output logic                 frame_valid,
  output logic                 overrun,
  output logic                 seg_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [FRM_CNT_W-1:0] frame_cnt
);

  localparam logic [ERR_CNT_W-1:0] ERR_ONE = ERR_CNT_W'(1);
  localparam logic [FRM_CNT_W-1:0] FRM_ONE = FRM_CNT_W'(1);

  state_t               state_q, state_d;
  logic [2:0]           idx_q, idx_d;
  logic [31:0]          word_q, word_d;
  logic [31:0]          frame_data_q, frame_data_d;
  logic                 frame_valid_q, frame_valid_d;
  logic                 overrun_q, overrun_d;
  logic                 seg_err_q, seg_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [FRM_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  logic [3:0]  dig_nib;
  logic        dig_vld;
  logic        store, complete, err, publish;
  logic [31:0] assembled;

  sevseg_digit_decode u_digit_decode (
    .pattern (sev_out),
    .nibble  (dig_nib),
    .valid   (dig_vld)
  );

  always_ff @(posedge clk_7seg) begin
    if (Rst) begin
      state_q <= HUNT;
      idx_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (!cap_en || err) begin
      state_d = HUNT;
      idx_d   = 3'd0;
    end else if (store) begin
      if (complete) begin
        state_d = HUNT;
        idx_d   = 3'd0;
      end else begin
        state_d = COLLECT;
        idx_d   = idx_q + 3'd1;
      end
    end
  end

  // HUNT silently waits for digit 0; any other digit there is not an error
  always_comb begin
    store = 1'b0;
    err   = 1'b0;
    if (cap_en) begin
      if (!dig_vld)                      err   = 1'b1;
      else if (state_q == HUNT)          store = (an == AN_A0);
      else if (an == AN_SEL[idx_q])      store = 1'b1;
      else                               err   = 1'b1;
    end
    complete = store && (state_q == COLLECT) && (idx_q == 3'd7);
  end

  always_comb begin
    word_d = word_q;
    if (store) word_d[{idx_q, 2'b00} +: 4] = dig_nib;
  end

  assign assembled = {dig_nib, word_q[27:0]};

`ifdef SEVSEG_DEC_STABLE_EN
  logic [31:0] cmp_q, cmp_d;
  logic        cmp_vld_q, cmp_vld_d;

  assign publish = complete && cmp_vld_q && (assembled == cmp_q);

  always_comb begin
    cmp_d     = cmp_q;
    cmp_vld_d = cmp_vld_q;
    if (err) begin
      cmp_d     = 32'd0;
      cmp_vld_d = 1'b0;
    end else if (complete && !publish) begin
      cmp_d     = assembled;
      cmp_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk_7seg) begin
    if (Rst) begin
      cmp_q     <= 32'd0;
      cmp_vld_q <= 1'b0;
    end else begin
      cmp_q     <= cmp_d;
      cmp_vld_q <= cmp_vld_d;
    end
  end
`else
  assign publish = complete;
`endif

  // An ack on the completion cycle frees the slot, so the new word replaces the old one
  always_comb begin
    frame_data_d  = frame_data_q;
    frame_valid_d = frame_valid_q;
    overrun_d     = overrun_q;
    frame_cnt_d   = frame_cnt_q;
    if (frame_valid_q && frame_ack) frame_valid_d = 1'b0;
    if (publish) begin
      if (frame_valid_q && !frame_ack) begin
        overrun_d = 1'b1;
      end else begin
        frame_data_d  = assembled;
        frame_valid_d = 1'b1;
        frame_cnt_d   = frame_cnt_q + FRM_ONE;
      end
    end
    seg_err_d = err;
    err_cnt_d = (err && (err_cnt_q != '1)) ? err_cnt_q + ERR_ONE : err_cnt_q;
  end

  always_ff @(posedge clk_7seg) begin
    if (Rst) begin
      word_q        <= 32'd0;
      frame_data_q  <= 32'd0;
      frame_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
      seg_err_q     <= 1'b0;
      err_cnt_q     <= '0;
      frame_cnt_q   <= '0;
    end else begin
      word_q        <= word_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
      overrun_q     <= overrun_d;
      seg_err_q     <= seg_err_d;
      err_cnt_q     <= err_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign frame_data  = frame_data_q;
  assign frame_valid = frame_valid_q;
  assign overrun     = overrun_q;
  assign seg_err     = seg_err_q;
  assign err_cnt     = err_cnt_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_sevseg_frame_decoder.sv
// Bench for sevseg_frame_decoder: directed scans plus random traffic checked every cycle
// against a frame-level model built from the digit table and publish/ack rules.
module tb_sevseg_frame_decoder;

  logic        clk_7seg = 1'b0;
  logic        Rst = 1'b1;
  logic [7:0]  an = 8'hFF;
  logic [6:0]  sev_out = 7'h7F;
  logic        cap_en = 1'b0;
  logic        frame_ack = 1'b0;
  logic [31:0] frame_data;
  logic        frame_valid;
  logic        overrun;
  logic        seg_err;
  logic [7:0]  err_cnt;
  logic [15:0] frame_cnt;

  sevseg_frame_decoder #(.ERR_CNT_W(8), .FRM_CNT_W(16)) dut (
    .clk_7seg    (clk_7seg),
    .Rst         (Rst),
    .an          (an),
    .sev_out     (sev_out),
    .cap_en      (cap_en),
    .frame_ack   (frame_ack),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .overrun     (overrun),
    .seg_err     (seg_err),
    .err_cnt     (err_cnt),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk_7seg = ~clk_7seg;

  // Display codes for hex 0..F, active-low {a..g}
  logic [6:0] seg_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [3:0]  partial[$];
  logic [31:0] m_data;
  logic        m_valid, m_over, m_seg;
  int          m_errc;
  logic [15:0] m_cnt;
  logic [31:0] m_cmp;
  logic        m_cmp_vld;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic int decode(input logic [6:0] s);
    int r = -1;
    for (int i = 0; i < 16; i++) if (seg_tab[i] == s) r = i;
    return r;
  endfunction

  function automatic int digit_of(input logic [7:0] a);
    int r = -1;
    for (int k = 0; k < 8; k++) if (a == ~(8'h01 << k)) r = k;
    return r;
  endfunction

  function automatic logic [7:0] an_of(input int k);
    logic [7:0] one = 8'h01;
    return ~(one << k);
  endfunction

  task automatic model(input logic [7:0] a, input logic [6:0] s, input logic c,
                       input logic k, input logic r);
    int d, dig;
    logic done, pub, old_v;
    logic [31:0] w;
    done = 1'b0;
    pub  = 1'b0;
    w    = 32'd0;
    if (r) begin
      partial.delete();
      m_data = 0; m_valid = 0; m_over = 0; m_seg = 0; m_errc = 0; m_cnt = 0;
      m_cmp = 0; m_cmp_vld = 0;
      return;
    end
    m_seg = 1'b0;
    d   = decode(s);
    dig = digit_of(a);
    if (!c) partial.delete();
    else if (d < 0) begin
      m_seg = 1'b1; partial.delete();
    end else if (partial.size() == 0) begin
      if (dig == 0) partial.push_back(4'(d));
    end else if (dig == partial.size()) begin
      partial.push_back(4'(d));
      if (partial.size() == 8) begin
        for (int i = 0; i < 8; i++) w[4*i +: 4] = partial[i];
        done = 1'b1;
        partial.delete();
      end
    end else begin
      m_seg = 1'b1; partial.delete();
    end
    if (m_seg && m_errc < 255) m_errc++;
`ifdef SEVSEG_DEC_STABLE_EN
    if (m_seg) begin m_cmp = 0; m_cmp_vld = 0; end
    if (done) begin
      if (m_cmp_vld && m_cmp == w) pub = 1'b1;
      else begin m_cmp = w; m_cmp_vld = 1'b1; end
    end
`else
    pub = done;
`endif
    old_v = m_valid;
    if (old_v && k) m_valid = 1'b0;
    if (pub) begin
      if (old_v && !k) m_over = 1'b1;
      else begin m_data = w; m_valid = 1'b1; m_cnt = m_cnt + 16'd1; end
    end
  endtask

  task automatic step(input logic [7:0] a, input logic [6:0] s, input logic c,
                      input logic k, input logic r);
    an = a; sev_out = s; cap_en = c; frame_ack = k; Rst = r;
    @(posedge clk_7seg);
    #1;
    model(a, s, c, k, r);
    chk("frame_data", frame_data, m_data);
    chk("frame_valid", 32'(frame_valid), 32'(m_valid));
    chk("overrun", 32'(overrun), 32'(m_over));
    chk("seg_err", 32'(seg_err), 32'(m_seg));
    chk("err_cnt", 32'(err_cnt), 32'(m_errc));
    chk("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
  endtask

  task automatic idle(input logic k);
    step(8'hFF, 7'h7F, 1'b0, k, 1'b0);
  endtask

  task automatic do_reset();
    step(8'hFF, 7'h7F, 1'b0, 1'b0, 1'b1);
  endtask

  // Scans digits 0..n-1 of w; ack_mode 0 none, 1 on the last digit only, 2 random
  task automatic scan(input logic [31:0] w, input int n, input int ack_mode);
    logic k;
    for (int i = 0; i < n; i++) begin
      k = (ack_mode == 2) ? 1'($urandom_range(0, 3) == 0) : (ack_mode == 1 && i == n - 1);
      step(an_of(i), seg_tab[w[4*i +: 4]], 1'b1, k, 1'b0);
    end
  endtask

  logic [31:0] last_w;

  initial begin
    do_reset();
    do_reset();
    chk("rst_data", frame_data, 32'd0);
    chk("rst_valid", 32'(frame_valid), 32'd0);
    chk("rst_cnt", 32'(frame_cnt), 32'd0);

    scan(32'h89ABCDEF, 8, 0);
`ifndef SEVSEG_DEC_STABLE_EN
    chk("basic_data", frame_data, 32'h89ABCDEF);
    chk("basic_valid", 32'(frame_valid), 32'd1);
    chk("basic_cnt", 32'(frame_cnt), 32'd1);
`endif
    idle(1'b1);
    chk("ack_clears", 32'(frame_valid), 32'd0);

    do_reset();
    scan(32'h00000001, 8, 0);
    scan(32'h00000002, 8, 0);
`ifndef SEVSEG_DEC_STABLE_EN
    chk("ovr_data", frame_data, 32'h00000001);
    chk("ovr_flag", 32'(overrun), 32'd1);
    chk("ovr_cnt", 32'(frame_cnt), 32'd1);
`endif

    do_reset();
    scan(32'h12345678, 2, 0);
    step(an_of(3), seg_tab[4], 1'b1, 1'b0, 1'b0);
    chk("seq_err", 32'(seg_err), 32'd1);
    chk("seq_errcnt", 32'(err_cnt), 32'd1);
    chk("seq_nopub", 32'(frame_valid), 32'd0);
    idle(1'b0);
    chk("err_pulse_end", 32'(seg_err), 32'd0);
    scan(32'h12345678, 8, 0);
`ifndef SEVSEG_DEC_STABLE_EN
    chk("after_err_data", frame_data, 32'h12345678);
`endif

    do_reset();
    scan(32'h00000000, 2, 0);
    step(an_of(2), 7'b1111111, 1'b1, 1'b0, 1'b0);
    chk("bad_seg_err", 32'(seg_err), 32'd1);
    for (int i = 0; i < 300; i++) step(8'hFF, 7'b1111111, 1'b1, 1'b0, 1'b0);
    chk("err_sat", 32'(err_cnt), 32'd255);
    step(8'h00, 7'b1111111, 1'b0, 1'b0, 1'b0);
    chk("no_err_cap_off", 32'(seg_err), 32'd0);

    do_reset();
    scan(32'hCAFE0123, 8, 0);
    scan(32'h0BADF00D, 8, 1);
`ifndef SEVSEG_DEC_STABLE_EN
    chk("ack_cmpl_data", frame_data, 32'h0BADF00D);
    chk("ack_cmpl_valid", 32'(frame_valid), 32'd1);
    chk("ack_cmpl_ovr", 32'(overrun), 32'd0);
`endif
    scan(32'h55667788, 5, 0);
    step(an_of(5), seg_tab[6], 1'b1, 1'b0, 1'b1);
    chk("mid_rst_data", frame_data, 32'd0);
    chk("mid_rst_valid", 32'(frame_valid), 32'd0);
    chk("mid_rst_cnt", 32'(frame_cnt), 32'd0);

`ifdef SEVSEG_DEC_STABLE_EN
    do_reset();
    scan(32'hA5A5A5A5, 8, 0);
    chk("stable_first", 32'(frame_valid), 32'd0);
    scan(32'hA5A5A5A5, 8, 0);
    chk("stable_second", 32'(frame_valid), 32'd1);
    chk("stable_data", frame_data, 32'hA5A5A5A5);
`endif

    do_reset();
    last_w = $urandom;
    for (int t = 0; t < 400; t++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind < 5) begin
        if ($urandom_range(0, 2) != 0) last_w = $urandom;
        scan(last_w, 8, 2);
      end else if (kind < 8) begin
        scan(last_w, $urandom_range(1, 7), 2);
        step(8'($urandom), 7'($urandom), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'b0);
      end else begin
        for (int i = 0; i < $urandom_range(1, 4); i++)
          step(8'($urandom), 7'($urandom), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'b0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
